// File: rtl/conv_layer_sched_if.sv
// Control and handshake bundle between the conv layer scheduler, the conv engine,
// the partial-sum accumulator and the downstream pooling/storage stage.
interface conv_layer_sched_if #(
    parameter int CH_W  = 2,
    parameter int FLT_W = 2
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             eng_rst;
    logic             eng_en;
    logic             eng_done;
    logic [CH_W-1:0]  ch_sel;
    logic [FLT_W-1:0] flt_sel;
    logic             acc_wr;
    logic             acc_first;
    logic             out_valid;
    logic             out_ready;
    logic [FLT_W-1:0] out_filter;
    logic             layer_done;
    logic             timeout_err;

    modport master (
        input  start, abort, eng_done, out_ready,
        output busy, eng_rst, eng_en, ch_sel, flt_sel, acc_wr, acc_first,
               out_valid, out_filter, layer_done, timeout_err
    );

    modport slave (
        output start, abort, eng_done, out_ready,
        input  busy, eng_rst, eng_en, ch_sel, flt_sel, acc_wr, acc_first,
               out_valid, out_filter, layer_done, timeout_err
    );
endinterface

// File: rtl/conv_layer_sched.sv
// Layer scheduler: walks every (filter, input channel) job through one shared conv
// engine, drives the partial-sum accumulator and hands finished filters downstream.
module conv_layer_sched #(
    parameter int NUM_IN_CH   = 3,
    parameter int NUM_FILTERS = 4,
    parameter int MAX_WAIT    = 1024,
    parameter int CH_W        = (NUM_IN_CH > 1) ? $clog2(NUM_IN_CH) : 1,
    parameter int FLT_W       = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input logic                clk,
    input logic                reset,
    conv_layer_sched_if.master bus
);
    localparam int               WD_W     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_IN_CH - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(NUM_FILTERS - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        ACC   = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [FLT_W-1:0] flt_q, flt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             abort_rst_q, abort_rst_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            flt_q       <= '0;
            wd_q        <= '0;
            abort_rst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            flt_q       <= flt_d;
            wd_q        <= wd_d;
            abort_rst_q <= abort_rst_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        flt_d       = flt_q;
        wd_d        = wd_q;
        abort_rst_d = 1'b0;
        // Abort wins over every other transition; it also restarts the engine on the way out.
        if (bus.abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            abort_rst_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = CLEAR;
                        ch_d    = '0;
                        flt_d   = '0;
                    end
                end
                CLEAR: begin
                    wd_d    = '0;
                    state_d = RUN;
                end
                RUN: begin
                    if (bus.eng_done) begin
                        state_d = ACC;
                    end else if (wd_q == WD_LAST) begin
                        state_d = ERR;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
                ACC: begin
                    if (ch_q == CH_LAST) begin
                        state_d = OUT;
                    end else begin
                        ch_d    = ch_q + 1'b1;
                        state_d = CLEAR;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        if (flt_q == FLT_LAST) begin
                            state_d = DONE;
                        end else begin
                            flt_d   = flt_q + 1'b1;
                            ch_d    = '0;
                            state_d = CLEAR;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    // Every output is a pure decode of registered state, so no input reaches an output.
    assign bus.busy        = (state_q != IDLE);
    assign bus.eng_rst     = (state_q == CLEAR) || abort_rst_q;
    assign bus.eng_en      = (state_q == RUN);
    assign bus.ch_sel      = ch_q;
    assign bus.flt_sel     = flt_q;
    assign bus.acc_wr      = (state_q == ACC);
    assign bus.acc_first   = (state_q == ACC) && (ch_q == '0);
    assign bus.out_valid   = (state_q == OUT);
    assign bus.out_filter  = flt_q;
    assign bus.layer_done  = (state_q == DONE);
    assign bus.timeout_err = (state_q == ERR);

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: engine and downstream models driven from per-job tables,
// event timing compared against a cycle-arithmetic reference of the layer schedule.
module tb_conv_layer_sched;
    localparam int NCH  = 3;
    localparam int NFLT = 2;
    localparam int MAXW = 16;
    localparam int NJOB = NCH * NFLT;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_layer_sched_if #(.CH_W(2), .FLT_W(1)) bus ();

    conv_layer_sched #(
        .NUM_IN_CH(NCH), .NUM_FILTERS(NFLT), .MAX_WAIT(MAXW), .CH_W(2), .FLT_W(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int done_tab[NJOB];
    int stall_tab[NFLT];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: done rises on RUN cycle done_tab[job] (0 = never), sticky until eng_rst.
    int ecnt;
    int cur_done;
    always @(posedge clk or posedge reset) begin
        if (reset) ecnt <= 0;
        else if (bus.eng_rst) ecnt <= 0;
        else if (bus.eng_en) ecnt <= ecnt + 1;
    end
    assign cur_done = done_tab[int'(bus.flt_sel) * NCH + int'(bus.ch_sel)];
    assign bus.eng_done = (cur_done != 0) && (ecnt >= cur_done - 1);

    // Downstream model: accepts after stall_tab[filter] cycles of presented valid.
    int vcnt;
    always @(posedge clk or posedge reset) begin
        if (reset) vcnt <= 0;
        else if (bus.out_valid && bus.out_ready) vcnt <= 0;
        else if (bus.out_valid) vcnt <= vcnt + 1;
    end
    assign bus.out_ready = (vcnt >= stall_tab[int'(bus.out_filter)]);

    int acc_cyc_q[$], acc_ch_q[$], acc_flt_q[$], acc_first_q[$];
    int hs_cyc_q[$], hs_flt_q[$], done_cyc_q[$];
    int rst_cnt = 0, en_cnt = 0, viol_cnt = 0;
    logic prev_valid = 1'b0, prev_hs = 1'b0;
    logic [0:0] prev_flt = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.acc_wr) begin
                acc_cyc_q.push_back(cyc);
                acc_ch_q.push_back(int'(bus.ch_sel));
                acc_flt_q.push_back(int'(bus.flt_sel));
                acc_first_q.push_back(int'(bus.acc_first));
            end
            if (bus.out_valid && bus.out_ready) begin
                hs_cyc_q.push_back(cyc);
                hs_flt_q.push_back(int'(bus.out_filter));
            end
            if (bus.layer_done) done_cyc_q.push_back(cyc);
            if (bus.eng_rst) rst_cnt <= rst_cnt + 1;
            if (bus.eng_en) en_cnt <= en_cnt + 1;
            if (prev_valid && !prev_hs && (!bus.out_valid || bus.out_filter != prev_flt))
                viol_cnt <= viol_cnt + 1;
            prev_valid <= bus.out_valid;
            prev_hs    <= bus.out_valid && bus.out_ready;
            prev_flt   <= bus.out_filter;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({bus.busy, bus.eng_rst, bus.eng_en, bus.ch_sel, bus.flt_sel, bus.acc_wr,
                    bus.acc_first, bus.out_valid, bus.out_filter, bus.layer_done,
                    bus.timeout_err});
    endfunction

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Runs one full layer with the current tables and checks every event against
    // the schedule implied by the per-job RUN lengths and per-filter stalls.
    task automatic run_layer(input string name);
        int exp_acc[$];
        int exp_hs[$];
        int s, exp_done, total_run, t0, k, j;
        int a0, h0, d0, r0, e0, v0;
        s = 1;
        total_run = 0;
        for (int f = 0; f < NFLT; f++) begin
            for (int c = 0; c < NCH; c++) begin
                exp_acc.push_back(s + done_tab[f * NCH + c] + 1);
                total_run += done_tab[f * NCH + c];
                s = s + done_tab[f * NCH + c] + 2;
            end
            exp_hs.push_back(s + stall_tab[f]);
            s = s + stall_tab[f] + 1;
        end
        exp_done = s;

        a0 = acc_cyc_q.size(); h0 = hs_cyc_q.size(); d0 = done_cyc_q.size();
        r0 = rst_cnt; e0 = en_cnt; v0 = viol_cnt;
        pulse_start();
        t0 = cyc;
        check({name, "_start_busy"}, 32'(bus.busy), 32'd1);
        check({name, "_start_eng_rst"}, 32'(bus.eng_rst), 32'd1);
        check({name, "_start_sel"}, 32'({bus.flt_sel, bus.ch_sel}), 32'd0);
        k = 0;
        while (done_cyc_q.size() == d0 && k < 3000) begin
            tick();
            bus.start = bus.busy && ($urandom_range(0, 2) == 0);
            k++;
        end
        bus.start = 1'b0;
        if (k >= 3000) check({name, "_layer_done_seen"}, 32'd0, 32'd1);
        check({name, "_busy_after_done"}, 32'(bus.busy), 32'd0);

        check({name, "_acc_count"}, 32'(acc_cyc_q.size() - a0), 32'(NJOB));
        for (int i = 0; i < NJOB; i++) begin
            j = a0 + i;
            if (j < acc_cyc_q.size()) begin
                check($sformatf("%s_acc%0d_cyc", name, i), 32'(acc_cyc_q[j] - t0 + 1), 32'(exp_acc[i]));
                check($sformatf("%s_acc%0d_ch", name, i), 32'(acc_ch_q[j]), 32'(i % NCH));
                check($sformatf("%s_acc%0d_flt", name, i), 32'(acc_flt_q[j]), 32'(i / NCH));
                check($sformatf("%s_acc%0d_first", name, i), 32'(acc_first_q[j]), 32'((i % NCH) == 0));
            end
        end
        check({name, "_hs_count"}, 32'(hs_cyc_q.size() - h0), 32'(NFLT));
        for (int f = 0; f < NFLT; f++) begin
            if (h0 + f < hs_cyc_q.size()) begin
                check($sformatf("%s_hs%0d_cyc", name, f), 32'(hs_cyc_q[h0 + f] - t0 + 1), 32'(exp_hs[f]));
                check($sformatf("%s_hs%0d_filter", name, f), 32'(hs_flt_q[h0 + f]), 32'(f));
            end
        end
        if (d0 < done_cyc_q.size())
            check({name, "_layer_done_cyc"}, 32'(done_cyc_q[d0] - t0 + 1), 32'(exp_done));
        check({name, "_eng_rst_count"}, 32'(rst_cnt - r0), 32'(NJOB));
        check({name, "_run_cycles"}, 32'(en_cnt - e0), 32'(total_run));
        check({name, "_out_hold_violations"}, 32'(viol_cnt - v0), 32'd0);
        check({name, "_no_timeout"}, 32'(bus.timeout_err), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_time_limit: bench did not complete");
        $fatal(1, "global time limit");
    end

    initial begin
        int k, a1, h1, d1, r1, e1;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick();
        tick();
        check("reset_outputs", all_outputs(), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_outputs", all_outputs(), 32'd0);

        // abort while idle must not pulse the engine
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("idle_abort_noop", all_outputs(), 32'd0);

        for (int i = 0; i < NJOB; i++) done_tab[i] = 10;
        for (int f = 0; f < NFLT; f++) stall_tab[f] = 0;
        run_layer("basic");

        stall_tab[0] = 5;
        run_layer("stall5");
        stall_tab[0] = 0;

        // done coinciding with the last watchdog cycle, plus minimum-length runs
        for (int i = 0; i < NJOB; i++) done_tab[i] = (i % 2 == 0) ? MAXW : 1;
        run_layer("edge_runs");

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NJOB; i++) done_tab[i] = int'($urandom_range(1, MAXW));
            for (int f = 0; f < NFLT; f++) stall_tab[f] = int'($urandom_range(0, 4));
            run_layer($sformatf("rand%0d", n));
        end
        for (int f = 0; f < NFLT; f++) stall_tab[f] = 0;

        // watchdog
        for (int i = 0; i < NJOB; i++) done_tab[i] = 0;
        e1 = en_cnt;
        pulse_start();
        k = 0;
        while (!bus.timeout_err && k < 100) begin tick(); k++; end
        if (k >= 100) check("err_entered", 32'd0, 32'd1);
        check("err_run_cycles", 32'(en_cnt - e1), 32'(MAXW));
        check("err_eng_en", 32'(bus.eng_en), 32'd0);
        check("err_busy", 32'(bus.busy), 32'd1);
        pulse_start();
        tick();
        check("err_start_ignored", 32'({bus.timeout_err, bus.busy, bus.eng_rst, bus.eng_en}), 32'b1100);
        r1 = rst_cnt;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("err_abort_state", 32'({bus.busy, bus.timeout_err, bus.eng_rst}), 32'b001);
        tick();
        tick();
        check("err_abort_rst_end", 32'(bus.eng_rst), 32'd0);
        check("err_abort_rst_once", 32'(rst_cnt - r1), 32'd1);

        // abort mid-run of the last job of filter 1
        for (int i = 0; i < NJOB; i++) done_tab[i] = 10;
        a1 = acc_cyc_q.size(); h1 = hs_cyc_q.size(); d1 = done_cyc_q.size();
        pulse_start();
        k = 0;
        while (!(bus.eng_en && bus.flt_sel == 1'b1 && bus.ch_sel == 2'd2) && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) check("abort_reach_run", 32'd0, 32'd1);
        tick();
        tick();
        check("abort_pre_acc", 32'(acc_cyc_q.size() - a1), 32'd5);
        check("abort_pre_hs", 32'(hs_cyc_q.size() - h1), 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_next_idle", 32'({bus.busy, bus.eng_rst, bus.eng_en, bus.acc_wr, bus.out_valid}), 32'b01000);
        for (int i = 0; i < 20; i++) tick();
        check("abort_no_acc", 32'(acc_cyc_q.size() - a1), 32'd5);
        check("abort_no_hs", 32'(hs_cyc_q.size() - h1), 32'd1);
        check("abort_no_done", 32'(done_cyc_q.size() - d1), 32'd0);
        run_layer("after_abort");

        // asynchronous reset while presenting a result
        for (int i = 0; i < NJOB; i++) done_tab[i] = 2;
        stall_tab[0] = 20;
        pulse_start();
        k = 0;
        while (!bus.out_valid && k < 200) begin tick(); k++; end
        if (k >= 200) check("rst_reach_out", 32'd0, 32'd1);
        tick();
        tick();
        check("rst_in_out", 32'(bus.out_valid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("rst_async_outputs", all_outputs(), 32'd0);
        tick();
        reset = 1'b0;
        stall_tab[0] = 0;
        tick();
        check("rst_idle", all_outputs(), 32'd0);
        for (int i = 0; i < NJOB; i++) done_tab[i] = 3;
        run_layer("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_layer_sched.md
Name: conv_layer_sched

Overview:
- Sequences one shared conv engine across a full layer of NUM_FILTERS output filters × NUM_IN_CH input channels.
- Per job: selects the ifmap channel and weight bank, restarts the engine, waits for its sticky done flag, and commands the external partial-sum accumulator.
- Hands each finished filter to the downstream pooling/storage stage over a valid/ready handshake.
- Sits between the top-level layer controller and the conv engine.

Parameters:
NUM_IN_CH, 3, input channels per filter (≥1)
NUM_FILTERS, 4, output filters per layer (≥1)
MAX_WAIT, 1024, maximum RUN cycles without engine done before timeout
CH_W, $clog2(NUM_IN_CH) min 1, channel index width
FLT_W, $clog2(NUM_FILTERS) min 1, filter index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
start  in  1  layer start pulse; sampled only in IDLE
abort  in  1  synchronous abort, any state
busy  out  1  high in every state except IDLE
eng_rst  out  1  engine restart pulse; clears engine counters and done
eng_en  out  1  engine enable
eng_done  in  1  engine done; sticky until eng_rst
ch_sel  out  CH_W  ifmap channel select and weight channel select
flt_sel  out  FLT_W  weight filter select
acc_wr  out  1  accumulator write strobe, 1 cycle
acc_first  out  1  with acc_wr: overwrite instead of add
out_valid  out  1  filter result ready downstream
out_ready  in  1  downstream accept
out_filter  out  FLT_W  filter index of the presented result
layer_done  out  1  1-cycle pulse at end of layer
timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0: busy, eng_rst, eng_en, ch_sel, flt_sel, acc_wr, acc_first, out_valid, out_filter, layer_done, timeout_err.
  - Watchdog counter 0.
- States: IDLE, CLEAR, RUN, ACC, OUT, DONE, ERR. All outputs are registered or decoded directly from state; no combinational path from any input to any output.
- IDLE:
  - start=1 → CLEAR with ch=0, flt=0.
  - Otherwise stay.
- CLEAR (1 cycle):
  - eng_rst=1, eng_en=0, watchdog cleared → RUN.
- RUN:
  - eng_en=1; watchdog increments each cycle.
  - eng_done=1 → ACC.
  - Otherwise, watchdog reaching MAX_WAIT-1 → ERR.
  - eng_done has priority over timeout in the same cycle.
- ACC (1 cycle):
  - eng_en=0, acc_wr=1, acc_first=(ch==0).
  - If ch==NUM_IN_CH-1 → OUT.
  - Else ch++ → CLEAR.
- OUT:
  - out_valid=1, out_filter=flt.
  - Stays until out_ready=1. out_valid must not drop and out_filter must not change before the handshake.
  - On handshake: if flt==NUM_FILTERS-1 → DONE; else flt++, ch=0 → CLEAR.
- DONE (1 cycle):
  - layer_done=1 → IDLE.
- ERR:
  - timeout_err=1 (sticky), eng_en=0, busy=1.
  - start ignored.
  - Exits only on abort or reset.
- ch_sel/flt_sel:
  - Stable from CLEAR through ACC of a job.
  - Change only on the ACC→CLEAR or OUT→CLEAR transition.
  - Hold last value in IDLE/DONE until the next start, which reloads 0.
- abort:
  - In any non-IDLE state: next state IDLE, eng_rst=1 for that one cycle, timeout_err cleared, no acc_wr, no out_valid, no layer_done.
  - abort has priority over every other transition.
  - abort in IDLE is a no-op.
- start while busy: ignored; no restart, no queueing.
- Stale eng_done (still high from the previous job) is never observed in RUN, because CLEAR precedes every RUN.
- Cycle cost per job = 2 + (RUN cycles until eng_done). OUT costs ≥1 cycle. DONE costs 1 cycle.
- Reset mid-operation: immediate return to reset values; the engine is not pulsed by this block.
- Counter wrap: ch and flt never exceed NUM_IN_CH-1 / NUM_FILTERS-1. NUM_IN_CH=1 gives acc_first=1 on every acc_wr.

Test Plan:
1. NUM_IN_CH=3, NUM_FILTERS=2, engine model raising eng_done on the 10th RUN cycle, out_ready=1; start pulse → 6 acc_wr pulses, acc_first on the 1st and 4th; 2 out handshakes with out_filter 0 then 1; layer_done in the 75th cycle after start is sampled; busy low the next cycle.
2. Same, but out_ready held 0 for 5 cycles at filter 0 → out_valid held 6 cycles with out_filter=0 stable; next eng_rst occurs only after the handshake; layer_done delayed by exactly 5 cycles.
3. MAX_WAIT=16, engine never asserts done → ERR entered after 16 RUN cycles; timeout_err=1, eng_en=0, busy=1; a start pulse is ignored; abort → IDLE, timeout_err=0, eng_rst pulses once.
4. abort during RUN of filter 1, channel 2 → next cycle IDLE; no further acc_wr/out_valid/layer_done; a new start restarts at ch_sel=0, flt_sel=0 with acc_first=1.
5. Engine leaves eng_done high after each job → every RUN is preceded by an eng_rst cycle, and no ACC occurs in the cycle immediately after CLEAR unless the model reasserts done; eng_done and timeout coinciding on cycle MAX_WAIT-1 → ACC, no error.
6. Reset asserted asynchronously mid-OUT → all outputs 0 immediately; start pulses during busy are checked to have no effect in every state.
